work_clock_pps: RTL and testbench

- Parametrised operating-time counter driven by an external one-second pulse (PPS), with sub-second resolution.
- Adds PPS quality checking (early pulses rejected), holdover on PPS loss via an internal tick, preset load, coherent snapshot and selectable wrap/saturate.
- Sits in the housekeeping path; its outputs feed status registers and timestamping.

---
 rtl/work_clock_pps.sv | 150 +++++++++++++++
 tb/tb_work_clock_pps.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/work_clock_pps.sv
// Operating-time counter disciplined by an external one-second pulse, with
// early-pulse rejection, holdover on PPS loss, preset load and snapshot.
module work_clock_pps #(
  parameter int CNT_W       = 32,
  parameter int FRAC_W      = 28,
  parameter int CLK_HZ      = 100000000,
  parameter int TOL         = 1000,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sec,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  input  logic              latch,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [FRAC_W-1:0] frac_cnt,
  output logic [CNT_W-1:0]  snap_sec,
  output logic [FRAC_W-1:0] snap_frac,
  output logic              snap_vld,
  output logic              tick_out,
  output logic              pps_ok,
  output logic              holdover,
  output logic              pps_err,
  output logic              ovf
);

  localparam logic [1:0] ACQUIRE  = 2'd0;
  localparam logic [1:0] LOCKED   = 2'd1;
  localparam logic [1:0] HOLDOVER = 2'd2;

  localparam logic [FRAC_W-1:0] F_EARLY = FRAC_W'(CLK_HZ - 1 - TOL);
  localparam logic [FRAC_W-1:0] F_LATE  = FRAC_W'(CLK_HZ - 1 + TOL);
  localparam logic [FRAC_W-1:0] F_SEC   = FRAC_W'(CLK_HZ - 1);
  localparam logic [FRAC_W-1:0] F_HALF  = FRAC_W'(CLK_HZ / 2);
  localparam logic [FRAC_W-1:0] F_TOL   = FRAC_W'(TOL);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out;
  logic                   pps_edge;
  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic                   inc;
  logic                   frac_zero;
  logic                   frac_tol;
  logic                   early;
  logic [CNT_W-1:0]       sec_next;
  logic                   sec_full;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign pps_edge = sync_out & ~prev_q;
  assign pps_ok   = (state_q == LOCKED);
  assign holdover = (state_q == HOLDOVER);

  // At all-ones the counter either wraps to zero or holds, depending on SATURATE.
  assign sec_full = (sec_cnt == '1);
  assign sec_next = !sec_full     ? sec_cnt + CNT_W'(1) :
                    (SATURATE != 0) ? sec_cnt : '0;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    inc       = 1'b0;
    frac_zero = 1'b0;
    frac_tol  = 1'b0;
    early     = 1'b0;
    case (state_q)
      ACQUIRE: begin
        if (pps_edge) begin
          inc       = 1'b1;
          frac_zero = 1'b1;
          state_d   = LOCKED;
        end
      end
      LOCKED: begin
        if (pps_edge) begin
          if (frac_cnt >= F_EARLY) begin
            inc       = 1'b1;
            frac_zero = 1'b1;
          end else begin
            early = 1'b1;
          end
        end else if (frac_cnt == F_LATE) begin
          // PPS overdue: count the missed second and restart phase as if it came at f=CLK_HZ-1.
          inc      = 1'b1;
          frac_tol = 1'b1;
          state_d  = HOLDOVER;
        end
      end
      HOLDOVER: begin
        if (pps_edge) begin
          inc       = (frac_cnt >= F_HALF);
          frac_zero = 1'b1;
          state_d   = LOCKED;
        end else if (frac_cnt == F_SEC) begin
          inc       = 1'b1;
          frac_zero = 1'b1;
        end
      end
      default: state_d = ACQUIRE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, which is what makes the snapshot capture old counts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      state_q   <= ACQUIRE;
      sec_cnt   <= '0;
      frac_cnt  <= '0;
      snap_sec  <= '0;
      snap_frac <= '0;
      snap_vld  <= 1'b0;
      tick_out  <= 1'b0;
      pps_err   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sec};
      prev_q   <= sync_out;
      pps_err  <= early;
      snap_vld <= latch;
      if (latch) begin
        snap_sec  <= sec_cnt;
        snap_frac <= frac_cnt;
      end
      if (load) begin
        sec_cnt  <= load_val;
        frac_cnt <= '0;
        ovf      <= 1'b0;
        tick_out <= 1'b0;
      end else begin
        state_q  <= state_d;
        tick_out <= inc;
        if (inc) begin
          sec_cnt <= sec_next;
          if (sec_full) ovf <= 1'b1;
        end
        if (frac_zero)            frac_cnt <= '0;
        else if (frac_tol)        frac_cnt <= F_TOL;
        else if (frac_cnt != '1)  frac_cnt <= frac_cnt + FRAC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_work_clock_pps.sv
// Scoreboard bench for work_clock_pps: stimulus pushes expected ticks, error
// pulses and snapshots; negedge monitors pop and compare when the DUT presents them.
module tb_work_clock_pps;

  localparam int CNT_W  = 32;
  localparam int FRAC_W = 16;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [CNT_W-1:0] scnt;
    logic             sovf;
    int               at;
  } tick_exp_t;

  typedef struct {
    logic [CNT_W-1:0]  cnt;
    logic [FRAC_W-1:0] frac;
    int                at;
  } err_exp_t;

  typedef struct {
    logic [CNT_W-1:0]  sec;
    logic [FRAC_W-1:0] frac;
    int                at;
  } snap_exp_t;

  logic clk, rst, sec, load, latch;
  logic [CNT_W-1:0] load_val;

  logic [CNT_W-1:0]  sec_cnt, snap_sec, s_sec_cnt, s_snap_sec;
  logic [FRAC_W-1:0] frac_cnt, snap_frac, s_frac_cnt, s_snap_frac;
  logic snap_vld, tick_out, pps_ok, holdover, pps_err, ovf;
  logic s_snap_vld, s_tick_out, s_pps_ok, s_holdover, s_pps_err, s_ovf;

  work_clock_pps #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .CLK_HZ(1000), .TOL(10),
                   .SYNC_STAGES(2), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .sec(sec), .load(load), .load_val(load_val), .latch(latch),
    .sec_cnt(sec_cnt), .frac_cnt(frac_cnt), .snap_sec(snap_sec), .snap_frac(snap_frac),
    .snap_vld(snap_vld), .tick_out(tick_out), .pps_ok(pps_ok), .holdover(holdover),
    .pps_err(pps_err), .ovf(ovf));

  work_clock_pps #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .CLK_HZ(1000), .TOL(10),
                   .SYNC_STAGES(2), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .sec(sec), .load(load), .load_val(load_val), .latch(latch),
    .sec_cnt(s_sec_cnt), .frac_cnt(s_frac_cnt), .snap_sec(s_snap_sec), .snap_frac(s_snap_frac),
    .snap_vld(s_snap_vld), .tick_out(s_tick_out), .pps_ok(s_pps_ok), .holdover(s_holdover),
    .pps_err(s_pps_err), .ovf(s_ovf));

  tick_exp_t tick_q[$];
  err_exp_t  err_q[$];
  snap_exp_t snap_q[$];

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  logic [CNT_W-1:0] m_cnt, s_cnt;
  logic             m_ovf, s_ovf_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle = cycle + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  task automatic push_inc(input int at);
    tick_exp_t e;
    if (m_cnt == '1) begin
      m_cnt = '0;
      m_ovf = 1'b1;
    end else begin
      m_cnt = m_cnt + 1;
    end
    if (s_cnt == '1) s_ovf_m = 1'b1;
    else             s_cnt   = s_cnt + 1;
    e = '{cnt: m_cnt, ovf: m_ovf, scnt: s_cnt, sovf: s_ovf_m, at: at};
    tick_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cycle < c) @(negedge clk);
  endtask

  // Rises sec for 5 cycles; latch/load are strobed in the edge cycle (rise+2).
  task automatic pps_pulse(input int gap, input bit with_latch, input bit with_load);
    sec = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        latch = with_latch;
        load  = with_load;
      end
      if (i == 3) begin
        latch = 1'b0;
        load  = 1'b0;
      end
    end
    sec = 1'b0;
    repeat (gap - 5) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sec_cnt"},   sec_cnt,   0);
    check({tag, "_frac_cnt"},  frac_cnt,  0);
    check({tag, "_snap_sec"},  snap_sec,  0);
    check({tag, "_snap_frac"}, snap_frac, 0);
    check({tag, "_flags"}, {snap_vld, tick_out, pps_ok, holdover, pps_err, ovf}, 0);
    check({tag, "_sat_cnt"},   s_sec_cnt, 0);
    check({tag, "_sat_flags"}, {s_snap_vld, s_tick_out, s_pps_ok, s_holdover, s_pps_err, s_ovf}, 0);
  endtask

  // Monitors
  always @(negedge clk) begin
    if (tick_out || s_tick_out) begin
      check("tick_expected", 64'(tick_q.size() > 0), 1);
      check("tick_both", {tick_out, s_tick_out}, 2'b11);
      if (tick_q.size() > 0) begin
        tick_exp_t e;
        e = tick_q.pop_front();
        check("tick_cnt",     sec_cnt,   e.cnt);
        check("tick_ovf",     ovf,       e.ovf);
        check("tick_sat_cnt", s_sec_cnt, e.scnt);
        check("tick_sat_ovf", s_ovf,     e.sovf);
        check("tick_cycle",   cycle,     e.at);
      end
    end
    if (pps_err) begin
      check("err_expected", 64'(err_q.size() > 0), 1);
      if (err_q.size() > 0) begin
        err_exp_t e;
        e = err_q.pop_front();
        check("err_cnt",   sec_cnt,  e.cnt);
        check("err_frac",  frac_cnt, e.frac);
        check("err_cycle", cycle,    e.at);
      end
    end
    if (snap_vld) begin
      check("snap_expected", 64'(snap_q.size() > 0), 1);
      if (snap_q.size() > 0) begin
        snap_exp_t e;
        e = snap_q.pop_front();
        check("snap_sec",   snap_sec,  e.sec);
        check("snap_frac",  snap_frac, e.frac);
        check("snap_cycle", cycle,     e.at);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t6, t;
    rst = 1'b0; sec = 1'b0; load = 1'b0; latch = 1'b0; load_val = '0;
    m_cnt = '0; m_ovf = 1'b0; s_cnt = '0; s_ovf_m = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("pps_ok_before_first", pps_ok, 0);

    // Five on-time pulses; the fifth leaves a 400-cycle gap to an early pulse.
    for (int i = 1; i <= 5; i++) begin
      push_inc(cycle + 3);
      pps_pulse((i == 5) ? 400 : 1000, 1'b0, 1'b0);
      if (i == 1) check("pps_ok_after_first", pps_ok, 1);
    end

    // Early pulse: rejected, counters untouched (frac is 400 past the last tick).
    err_q.push_back('{cnt: 32'd5, frac: 16'd400, at: cycle + 3});
    pps_pulse(600, 1'b0, 1'b0);

    // On-time pulse to 6, then PPS stops.
    t6 = cycle + 3;
    push_inc(t6);
    pps_pulse(5, 1'b0, 1'b0);
    push_inc(t6 + 1010);
    push_inc(t6 + 2000);
    push_inc(t6 + 3000);
    wait_until(t6 + 1011);
    check("holdover_entered", {pps_ok, holdover}, 2'b01);
    check("holdover_cnt",     sec_cnt,  7);
    check("holdover_frac",    frac_cnt, 11);

    // Resume 200 cycles after the internal tick: relock without counting.
    wait_until(t6 + 3197);
    pps_pulse(1000, 1'b0, 1'b0);
    check("relock_state", {pps_ok, holdover}, 2'b10);
    check("relock_cnt",   sec_cnt,  9);
    check("relock_frac",  frac_cnt, 997);

    // Latch in the tick cycle captures the pre-tick values.
    push_inc(cycle + 3);
    snap_q.push_back('{sec: 32'd9, frac: 16'd999, at: cycle + 3});
    pps_pulse(1000, 1'b1, 1'b0);

    // Load coincident with a PPS edge (and a latch): no tick, old values snapped.
    load_val = 32'hFFFF_FFFE;
    snap_q.push_back('{sec: 32'd10, frac: 16'd999, at: cycle + 3});
    pps_pulse(1000, 1'b1, 1'b1);
    m_cnt = 32'hFFFF_FFFE; m_ovf = 1'b0;
    s_cnt = 32'hFFFF_FFFE; s_ovf_m = 1'b0;
    check("load_cnt",     sec_cnt,   32'hFFFF_FFFE);
    check("load_sat_cnt", s_sec_cnt, 32'hFFFF_FFFE);
    check("load_frac",    frac_cnt,  997);
    check("load_ovf",     {ovf, s_ovf}, 0);
    check("load_state",   pps_ok, 1);

    // Through all-ones: wrap vs saturate, then stop PPS and enter holdover.
    t = 0;
    for (int i = 0; i < 3; i++) begin
      t = cycle + 3;
      push_inc(t);
      pps_pulse((i < 2) ? 1000 : 5, 1'b0, 1'b0);
    end
    push_inc(t + 1010);
    wait_until(t + 1050);
    check("hold2_state", {pps_ok, holdover}, 2'b01);
    check("hold2_ovf",   {ovf, s_ovf}, 2'b11);

    // Reset in holdover with sec held high: everything clears, one edge after release.
    sec = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("midreset");
    m_cnt = '0; m_ovf = 1'b0; s_cnt = '0; s_ovf_m = 1'b0;
    push_inc(cycle + 3);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    sec = 1'b0;
    check("post_reset_state", {pps_ok, holdover}, 2'b10);
    check("post_reset_cnt",   sec_cnt, 1);

    repeat (20) @(negedge clk);
    check("tick_q_drained", tick_q.size(), 0);
    check("err_q_drained",  err_q.size(),  0);
    check("snap_q_drained", snap_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
